// File: rtl/dbg_log_arb_pkg.sv
// Shared definitions for the debug log arbiter: FSM state encoding and
// width helpers used to size the grant index and the flit counter.
package dbg_log_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Ceiling log2 with a fixed iteration bound so it stays synthesizable.
    function automatic int unsigned dbg_clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 32'd0) ? (value - 32'd1) : 32'd0;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (v > 32'd0) begin
                r = r + 32'd1;
                v = v >> 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Index width that is never zero, even for a single source.
    function automatic int unsigned dbg_sel_width(input int unsigned n);
        return (n > 32'd1) ? dbg_clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/dbg_log_arb_if.sv
// Bundle of the merged log streams: N packed AXI Stream inputs and one
// AXI Stream output carrying the source index on TDEST.
// master = the side that owns the input streams and the output sink,
// slave  = the arbiter itself.
interface dbg_log_arb_if
    import dbg_log_arb_pkg::*;
#(
    parameter int N_INPUTS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = int'(dbg_sel_width(N_INPUTS))
);
    logic [N_INPUTS*DATA_WIDTH-1:0] in_TDATA;
    logic [N_INPUTS-1:0]            in_TVALID;
    logic [N_INPUTS-1:0]            in_TREADY;
    logic [N_INPUTS-1:0]            in_TLAST;
    logic [DATA_WIDTH-1:0]          out_TDATA;
    logic                           out_TVALID;
    logic                           out_TREADY;
    logic                           out_TLAST;
    logic [SEL_WIDTH-1:0]           out_TDEST;

    modport master (
        output in_TDATA, in_TVALID, in_TLAST, out_TREADY,
        input  in_TREADY, out_TDATA, out_TVALID, out_TLAST, out_TDEST
    );

    modport slave (
        input  in_TDATA, in_TVALID, in_TLAST, out_TREADY,
        output in_TREADY, out_TDATA, out_TVALID, out_TLAST, out_TDEST
    );
endinterface

// File: rtl/dbg_log_arb_skid2.sv
// Generic 2-entry registered skid buffer. in_ready and every output come
// straight from flops; an empty buffer passes a word through in one cycle
// and sustains one word per cycle while out_ready stays high.
module axis_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             in_fire_s;
    logic             out_free_s;

    // Next-state: refill the output register from the skid slot first, else
    // from the input; park an input word in the skid slot while stalled.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire_s    = in_valid & in_ready_q;
        out_free_s   = ~out_valid_q | out_ready;
        if (out_free_s) begin
            if (skid_valid_q) begin
                // in_ready_q is low whenever the skid slot is full, so no
                // input word can arrive in this branch.
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end else begin
            skid_valid_d = skid_valid_q;
        end
        in_ready_d = ~skid_valid_d;
    end

    // State registers; reset empties both slots and opens the input.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/dbg_log_arb.sv
// Packet-aware round-robin merge of the per-governor log streams into one
// AXI Stream. The source index travels on TDEST; a length guard cuts
// packets at MAX_PKT flits so one source cannot hold the grant forever.
module dbg_log_arb
    import dbg_log_arb_pkg::*;
#(
    parameter int N_INPUTS   = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_PKT    = 256
) (
    input logic          clk,
    input logic          rst,
    dbg_log_arb_if.slave bus
);
    localparam int SEL_WIDTH = int'(dbg_sel_width(N_INPUTS));
    localparam int CNT_W     = int'(dbg_sel_width(MAX_PKT + 1));
    localparam int PAY_W     = DATA_WIDTH + 1 + SEL_WIDTH;
    localparam bit GUARD_EN  = (MAX_PKT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MAX_PKT > 0) ? (MAX_PKT - 1) : 0);

    arb_state_e            state_q, state_d;
    logic [SEL_WIDTH-1:0]  grant_q, grant_d;
    logic [SEL_WIDTH-1:0]  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [N_INPUTS-1:0]   in_ready_s;
    logic                  push_valid_s;
    logic                  push_last_s;
    logic [DATA_WIDTH-1:0] push_data_s;
    logic                  guard_hit_s;
    logic                  skid_in_ready_s;
    logic [PAY_W-1:0]      push_payload_s;
    logic                  skid_out_valid_s;
    logic [PAY_W-1:0]      skid_out_payload_s;

    // First valid source after 'last', wrapping modulo N_INPUTS, so the
    // previous owner is considered last.
    function automatic logic [SEL_WIDTH-1:0] rr_pick(
        input logic [N_INPUTS-1:0]  valid,
        input logic [SEL_WIDTH-1:0] last
    );
        logic [SEL_WIDTH-1:0] pick;
        logic                 found;
        int                   idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= N_INPUTS; i++) begin
            idx = (int'(last) + i) % N_INPUTS;
            if (!found && valid[idx]) begin
                pick  = SEL_WIDTH'(idx);
                found = 1'b1;
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Arbitration FSM: pick a source in IDLE (one bubble), then forward its
    // flits until TLAST or the length guard releases the grant.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        in_ready_s   = '0;
        push_valid_s = 1'b0;
        push_data_s  = '0;
        guard_hit_s  = GUARD_EN && (cnt_q == CNT_LAST);
        push_last_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|bus.in_TVALID) begin
                    grant_d = rr_pick(bus.in_TVALID, last_grant_q);
                    cnt_d   = '0;
                    state_d = LOCKED;
                end else begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                in_ready_s[grant_q] = skid_in_ready_s;
                push_data_s  = bus.in_TDATA[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                push_last_s  = bus.in_TLAST[grant_q] | guard_hit_s;
                push_valid_s = bus.in_TVALID[grant_q] & skid_in_ready_s;
                if (push_valid_s) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (push_last_s) begin
                        // A forced cut releases the grant just like TLAST;
                        // the rest of the packet competes afresh.
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    // A locked source that drops valid simply stalls here.
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbiter state registers; after reset input 0 has first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= SEL_WIDTH'(N_INPUTS - 1);
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign push_payload_s = {push_data_s, push_last_s, grant_q};

    axis_skid2 #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (push_valid_s),
        .in_ready (skid_in_ready_s),
        .in_data  (push_payload_s),
        .out_valid(skid_out_valid_s),
        .out_ready(bus.out_TREADY),
        .out_data (skid_out_payload_s)
    );

    assign bus.in_TREADY  = in_ready_s;
    assign bus.out_TVALID = skid_out_valid_s;
    assign bus.out_TDATA  = skid_out_payload_s[PAY_W-1 -: DATA_WIDTH];
    assign bus.out_TLAST  = skid_out_payload_s[SEL_WIDTH];
    assign bus.out_TDEST  = skid_out_payload_s[SEL_WIDTH-1:0];

endmodule

// File: tb/tb_dbg_log_arb.sv
// Directed bench for dbg_log_arb (3 inputs, MAX_PKT=4): single packet,
// round-robin contention, random backpressure, forced cut, reset
// mid-packet and grant wrap-around.
module tb_dbg_log_arb;
    localparam int N    = 3;
    localparam int DW   = 32;
    localparam int SW   = 2;
    localparam int MAXP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dbg_log_arb_if #(.N_INPUTS(N), .DATA_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

    dbg_log_arb #(.N_INPUTS(N), .DATA_WIDTH(DW), .MAX_PKT(MAXP)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Source model: per-input flit list {last, data} with a head pointer.
    logic [32:0]   src_mem [N][64];
    int            src_head [N];
    int            src_len [N];
    logic [N-1:0]  tb_valid;
    logic [N*DW-1:0] tb_data;
    logic [N-1:0]  tb_last;
    logic [N-1:0]  fire_v;
    logic          out_rdy = 1'b1;
    bit            out_rand = 1'b0;

    // Output log captured by the monitor.
    logic [31:0] log_data [128];
    logic        log_last [128];
    logic [1:0]  log_dest [128];
    int          log_cyc [128];
    int          log_n = 0;
    // Expected stream.
    logic [31:0] exp_data [128];
    logic        exp_last [128];
    logic [1:0]  exp_dest [128];
    int          exp_n = 0;

    int          ready_cnt [N];
    int          onehot_err = 0;
    int          stab_err = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [1:0]  prev_dest;

    always_comb begin
        tb_valid = '0;
        tb_data  = '0;
        tb_last  = '0;
        for (int i = 0; i < N; i++) begin
            tb_valid[i]         = (src_head[i] < src_len[i]);
            tb_data[i*DW +: DW] = src_mem[i][src_head[i] % 64][31:0];
            tb_last[i]          = src_mem[i][src_head[i] % 64][32];
        end
    end

    assign bus.in_TVALID  = tb_valid;
    assign bus.in_TDATA   = tb_data;
    assign bus.in_TLAST   = tb_last;
    assign bus.out_TREADY = out_rdy;

    always @(posedge clk) cyc <= cyc + 1;

    // Pop source flits that handshook at this edge.
    always @(posedge clk) begin
        fire_v = bus.in_TVALID & bus.in_TREADY;
        if (rst) fire_v = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire_v[i]) src_head[i] = src_head[i] + 1;
        end
    end

    // Downstream ready: constant 1 or a random bit per cycle.
    always @(posedge clk) begin
        #1;
        out_rdy = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor on the falling edge: log handshakes, watch stall stability
    // and in_TREADY one-hotness.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                if (bus.out_TVALID !== 1'b1 || bus.out_TDATA !== prev_data ||
                    bus.out_TLAST !== prev_last || bus.out_TDEST !== prev_dest)
                    stab_err++;
            end
            if (bus.out_TVALID && bus.out_TREADY && log_n < 128) begin
                log_data[log_n] = bus.out_TDATA;
                log_last[log_n] = bus.out_TLAST;
                log_dest[log_n] = bus.out_TDEST;
                log_cyc[log_n]  = cyc;
                log_n++;
            end
            prev_stall = bus.out_TVALID && !bus.out_TREADY;
            prev_data  = bus.out_TDATA;
            prev_last  = bus.out_TLAST;
            prev_dest  = bus.out_TDEST;
            for (int i = 0; i < N; i++) begin
                if (bus.in_TREADY[i]) ready_cnt[i]++;
            end
            if ($countones(bus.in_TREADY) > 1) onehot_err++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic load(input int src, input logic [31:0] d, input logic l);
        src_mem[src][src_len[src] % 64] = {l, d};
        src_len[src] = src_len[src] + 1;
    endtask

    task automatic add_exp(input logic [31:0] d, input logic l, input logic [1:0] dst);
        exp_data[exp_n] = d;
        exp_last[exp_n] = l;
        exp_dest[exp_n] = dst;
        exp_n++;
    endtask

    task automatic clear_logs();
        log_n = 0;
        exp_n = 0;
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
    endtask

    task automatic do_reset(input bit clr);
        @(negedge clk);
        rst = 1'b1;
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                src_head[i] = 0;
                src_len[i]  = 0;
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        @(negedge clk);
    endtask

    // Wait (bounded) for the expected flit count, then compare the stream.
    task automatic wait_out(input string tag);
        int budget;
        budget = 400;
        while (log_n < exp_n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq({tag, "_timeout"}, 32'(log_n >= exp_n), 32'd1);
        repeat (6) @(negedge clk);
        check_eq({tag, "_count"}, 32'(log_n), 32'(exp_n));
        for (int i = 0; i < exp_n && i < log_n; i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), log_data[i], exp_data[i]);
            check_eq($sformatf("%s_last%0d", tag, i), 32'(log_last[i]), 32'(exp_last[i]));
            check_eq($sformatf("%s_dest%0d", tag, i), 32'(log_dest[i]), 32'(exp_dest[i]));
        end
    endtask

    initial begin
        int t0;
        int budget;
        for (int i = 0; i < N; i++) begin
            src_head[i]  = 0;
            src_len[i]   = 0;
            ready_cnt[i] = 0;
            for (int j = 0; j < 64; j++) src_mem[i][j] = '0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_tvalid", 32'(bus.out_TVALID), 32'd0);
        check_eq("rst_tdata", bus.out_TDATA, 32'd0);
        check_eq("rst_tlast", 32'(bus.out_TLAST), 32'd0);
        check_eq("rst_tdest", 32'(bus.out_TDEST), 32'd0);
        check_eq("rst_tready", 32'(bus.in_TREADY), 32'd0);

        // Single packet from input 1
        clear_logs();
        t0 = cyc;
        load(1, 32'hA0, 1'b0);
        load(1, 32'hA1, 1'b0);
        load(1, 32'hA2, 1'b1);
        add_exp(32'hA0, 1'b0, 2'd1);
        add_exp(32'hA1, 1'b0, 2'd1);
        add_exp(32'hA2, 1'b1, 2'd1);
        wait_out("single");
        check_eq("single_latency", 32'(log_cyc[0] - t0), 32'd2);
        check_eq("single_tput", 32'(log_cyc[2] - log_cyc[0]), 32'd2);
        check_eq("single_rdy1", 32'(ready_cnt[1]), 32'd3);
        check_eq("single_rdy0", 32'(ready_cnt[0]), 32'd0);
        check_eq("single_rdy2", 32'(ready_cnt[2]), 32'd0);

        // Contention: all inputs valid from reset, input 0 has two packets
        do_reset(1'b1);
        load(0, 32'h10, 1'b0); load(0, 32'h11, 1'b1);
        load(0, 32'h12, 1'b0); load(0, 32'h13, 1'b1);
        load(1, 32'h20, 1'b0); load(1, 32'h21, 1'b1);
        load(2, 32'h30, 1'b0); load(2, 32'h31, 1'b1);
        add_exp(32'h10, 1'b0, 2'd0); add_exp(32'h11, 1'b1, 2'd0);
        add_exp(32'h20, 1'b0, 2'd1); add_exp(32'h21, 1'b1, 2'd1);
        add_exp(32'h30, 1'b0, 2'd2); add_exp(32'h31, 1'b1, 2'd2);
        add_exp(32'h12, 1'b0, 2'd0); add_exp(32'h13, 1'b1, 2'd0);
        wait_out("rr");
        check_eq("rr_inpkt", 32'(log_cyc[1] - log_cyc[0]), 32'd1);
        check_eq("rr_bubble1", 32'(log_cyc[2] - log_cyc[1]), 32'd2);
        check_eq("rr_bubble2", 32'(log_cyc[4] - log_cyc[3]), 32'd2);
        check_eq("rr_bubble3", 32'(log_cyc[6] - log_cyc[5]), 32'd2);

        // Backpressure: 20 flits from input 2, cut every 4 flits
        do_reset(1'b1);
        out_rand = 1'b1;
        for (int k = 0; k < 20; k++) begin
            load(2, 32'h300 + 32'(k), 1'(k == 19));
            add_exp(32'h300 + 32'(k), 1'((k % MAXP) == (MAXP - 1)), 2'd2);
        end
        wait_out("bp");
        out_rand = 1'b0;
        check_eq("bp_stable", 32'(stab_err), 32'd0);

        // Forced cut with a competing input
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) load(0, 32'h400 + 32'(k), 1'(k == 9));
        for (int k = 0; k < 3; k++) load(1, 32'h500 + 32'(k), 1'(k == 2));
        for (int k = 0; k < 4; k++) add_exp(32'h400 + 32'(k), 1'(k == 3), 2'd0);
        for (int k = 0; k < 3; k++) add_exp(32'h500 + 32'(k), 1'(k == 2), 2'd1);
        for (int k = 4; k < 8; k++) add_exp(32'h400 + 32'(k), 1'(k == 7), 2'd0);
        add_exp(32'h408, 1'b0, 2'd0);
        add_exp(32'h409, 1'b1, 2'd0);
        wait_out("cut");

        // Reset after flit 2 of a 5-flit packet from input 2
        do_reset(1'b1);
        for (int k = 0; k < 5; k++) load(2, 32'h600 + 32'(k), 1'(k == 4));
        budget = 100;
        while (src_head[2] < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_eq("mid_head", 32'(src_head[2]), 32'd2);
        rst = 1'b1;
        load(0, 32'h700, 1'b0);
        load(0, 32'h701, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_logs();
        @(negedge clk);
        check_eq("mid_tvalid", 32'(bus.out_TVALID), 32'd0);
        check_eq("mid_tlast", 32'(bus.out_TLAST), 32'd0);
        add_exp(32'h700, 1'b0, 2'd0);
        add_exp(32'h701, 1'b1, 2'd0);
        add_exp(32'h602, 1'b0, 2'd2);
        add_exp(32'h603, 1'b0, 2'd2);
        add_exp(32'h604, 1'b1, 2'd2);
        wait_out("mid");

        // Wrap: last grant 2, inputs 0 and 2 valid -> input 0
        do_reset(1'b1);
        load(2, 32'h800, 1'b1);
        add_exp(32'h800, 1'b1, 2'd2);
        wait_out("wrap_pre");
        clear_logs();
        load(0, 32'h900, 1'b1);
        load(2, 32'h801, 1'b1);
        add_exp(32'h900, 1'b1, 2'd0);
        add_exp(32'h801, 1'b1, 2'd2);
        wait_out("wrap");

        check_eq("tready_onehot", 32'(onehot_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dbg_log_arb.md
Name: dbg_log_arb

Overview:
Packet-aware round-robin arbiter that merges the per-governor log/receipt streams of a daisy-chained dbg_guv group into one 32-bit AXI Stream. It sits directly downstream of the dbg_guv instances' logs_receipts ports and feeds the single host-facing log channel. Each output packet carries its source index on TDEST, so the host can demultiplex without in-band headers. A maximum-length guard prevents a misbehaving source from holding the grant indefinitely.

Parameters:
N_INPUTS, 3, number of log streams merged (2..16)
DATA_WIDTH, 32, flit width of every input and of the output
MAX_PKT, 256, flits per packet before a forced TLAST and release; 0 disables the guard
SEL_WIDTH, clog2(N_INPUTS) (minimum 1), derived localparam; width of TDEST and of the grant index

Ports:
clk  in  1  clock; the only clock domain in the block
rst  in  1  synchronous reset, active high
in_TDATA  in  N_INPUTS*DATA_WIDTH  packed input data; input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
in_TVALID  in  N_INPUTS  per-input valid
in_TREADY  out  N_INPUTS  per-input ready; at most one bit is high in any cycle
in_TLAST  in  N_INPUTS  per-input end of packet
out_TDATA  out  DATA_WIDTH  merged data
out_TVALID  out  1  merged valid
out_TREADY  in  1  downstream ready
out_TLAST  out  1  end of packet; also asserted on a forced cut
out_TDEST  out  SEL_WIDTH  index of the source input

Behaviour:
- Reset and clocking: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - out_TVALID=0, out_TDATA=0, out_TLAST=0, out_TDEST=0.
  - in_TREADY=0.
  - state=IDLE, last_grant=N_INPUTS-1, so input 0 has first priority; flit counter=0.
  - Skid buffer is emptied.
- FSM, two states:
  - IDLE:
    - All in_TREADY=0.
    - If any in_TVALID is high, grant <= first valid index searching last_grant+1, +2, ... with modulo-N_INPUTS wrap; state <= LOCKED; counter <= 0.
    - No valid inputs -> stay in IDLE.
  - LOCKED:
    - in_TREADY[grant] = skid_in_ready; all other in_TREADY bits are 0.
    - On an accepted flit (valid & ready):
      - Push {data, last_eff, grant} into the skid buffer.
      - counter <= counter+1.
      - last_eff = in_TLAST[grant] | (MAX_PKT!=0 && counter==MAX_PKT-1).
    - If last_eff is set on the accepted flit: last_grant <= grant; state <= IDLE.
  - Arbitration costs exactly one bubble cycle per packet. Back-to-back packets from different sources are separated by at least 1 idle input cycle.
- Forced cut: the flit that reaches MAX_PKT is emitted with out_TLAST=1. The remainder of the source's packet is treated as a new packet and competes in round robin again; it gets no priority.
- Output stage: a 2-entry skid buffer.
  - All out_* signals are driven from registers.
  - skid_in_ready is a registered signal.
  - Latency: a flit accepted at edge t is visible on out_* after edge t (same cycle the next flit can be accepted), provided the buffer was empty.
  - Full throughput within a packet when out_TREADY stays 1.
  - Order and data are preserved under any out_TREADY pattern; nothing is dropped or duplicated.
- Valid dropped mid-packet by the locked source (AXIS violation): the arbiter simply stalls in LOCKED; no timeout.
- TDEST: equals the grant for every flit of the packet and is stable while out_TVALID=1 && !out_TREADY.
- Reset mid-packet:
  - Skid contents and the partial packet are discarded; no TLAST is emitted for the truncated packet.
  - The next packet starts from input 0's priority position.
- N_INPUTS=1: degenerates to a pass-through with a 1-cycle bubble per packet; TDEST=0.

Decomposition:
- Shared header with the existing dbg macros: a clog2 helper for SEL_WIDTH, plus FSM state encodings IDLE=1'b0 and LOCKED=1'b1.
- One sub-module: axis_skid2, a generic 2-entry registered skid buffer parameterised by payload width (DATA_WIDTH+1+SEL_WIDTH).
- The round-robin pick is a combinational function inside dbg_log_arb; it is not a separate module.

Test Plan:
- Single packet: input 1 sends 3 flits 0xA0,0xA1,0xA2 (TLAST on the last), out_TREADY=1 -> out shows the same 3 flits in order, TLAST only on 0xA2, TDEST=1, in_TREADY[1] high for 3 consecutive cycles.
- Contention: all 3 inputs hold 2-flit packets valid from reset -> output packet order is TDEST 0,1,2,0,...; no interleaving inside a packet; exactly 1 bubble between packets.
- Backpressure: 20-flit packet from input 2 with out_TREADY driven by random bits -> all 20 flits emerge exactly once and in order; out_* stay stable while stalled.
- Forced cut: MAX_PKT=4, input 0 sends a 10-flit packet while input 1 is valid -> out sequence is in0 flits 1-4 (TLAST on 4), then in1's packet, then in0 flits 5-8 (TLAST on 8), then in1 or in0 per round robin.
- Reset mid-packet: rst pulsed for 1 cycle after flit 2 of a 5-flit packet from input 2 -> out_TVALID=0 the cycle after reset; the next grant goes to input 0 when inputs 0 and 2 are both valid.
- Wrap: last_grant=2 with inputs 0 and 2 valid -> grant=0.
